// File: rtl/note_pkg.sv
`default_nettype none
// note_pkg -- shared types, pitch codes, tone half-periods and the default song (rev 1.0)
package note_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] arrows;
    logic [2:0] pitch;
  } note_t;

  localparam logic [2:0] P_REST = 3'd0;
  localparam logic [2:0] P_C4   = 3'd1;
  localparam logic [2:0] P_D4   = 3'd2;
  localparam logic [2:0] P_E4   = 3'd3;
  localparam logic [2:0] P_F4   = 3'd4;
  localparam logic [2:0] P_G4   = 3'd5;
  localparam logic [2:0] P_A4   = 3'd6;
  localparam logic [2:0] P_B4   = 3'd7;

  localparam longint DEFAULT_CLK_HZ = 100000000;

  // Frequencies kept in centi-hertz so the rounded division stays integer.
  function automatic longint half_period(input longint clk_hz, input int pitch);
    longint f_centi;
    case (pitch)
      1:       f_centi = 26163;
      2:       f_centi = 29366;
      3:       f_centi = 32963;
      4:       f_centi = 34923;
      5:       f_centi = 39200;
      6:       f_centi = 44000;
      7:       f_centi = 49388;
      default: f_centi = 0;
    endcase
    if (f_centi == 0) half_period = 0;
    else              half_period = (clk_hz * 100 + f_centi) / (2 * f_centi);
  endfunction

  localparam int unsigned HALF_PERIOD [8] = '{
    32'd0,
    32'(half_period(DEFAULT_CLK_HZ, 1)),
    32'(half_period(DEFAULT_CLK_HZ, 2)),
    32'(half_period(DEFAULT_CLK_HZ, 3)),
    32'(half_period(DEFAULT_CLK_HZ, 4)),
    32'(half_period(DEFAULT_CLK_HZ, 5)),
    32'(half_period(DEFAULT_CLK_HZ, 6)),
    32'(half_period(DEFAULT_CLK_HZ, 7))
  };

  // The default song is a four-note phrase repeated across the whole table.
  function automatic note_t song_entry(input int idx);
    case (idx % 4)
      0:       song_entry = '{arrows: 4'b0001, pitch: P_A4};
      1:       song_entry = '{arrows: 4'b0010, pitch: P_C4};
      2:       song_entry = '{arrows: 4'b0100, pitch: P_REST};
      default: song_entry = '{arrows: 4'b1000, pitch: P_G4};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_song_rom.sv
`default_nettype none
// song_rom -- combinational song table lookup by note index (rev 1.0)
module song_rom
  import note_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [3:0]       o_arrows,
  output logic [2:0]       o_pitch
);

  note_t w_entry;

  assign w_entry  = song_entry(int'(i_idx));
  assign o_arrows = w_entry.arrows;
  assign o_pitch  = w_entry.pitch;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// note_sequencer -- steps the song table once per beat, strobes each new note
// and drives a square-wave tone for its pitch (rev 1.0)
module note_sequencer
  import note_pkg::*;
#(
  parameter longint CLK_HZ   = 100000000,
  parameter int     SONG_LEN = 16,
  parameter int     IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_clk,
  input  logic             start,
  input  logic             pause,
  output logic [3:0]       arrows,
  output logic             note_valid,
  output logic [IDX_W-1:0] note_idx,
  output logic             tone,
  output logic             playing,
  output logic             done
);

  localparam int CNT_W = $clog2(half_period(CLK_HZ, 1));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0] HP [8] = '{
    CNT_W'(0),
    CNT_W'(half_period(CLK_HZ, 1)),
    CNT_W'(half_period(CLK_HZ, 2)),
    CNT_W'(half_period(CLK_HZ, 3)),
    CNT_W'(half_period(CLK_HZ, 4)),
    CNT_W'(half_period(CLK_HZ, 5)),
    CNT_W'(half_period(CLK_HZ, 6)),
    CNT_W'(half_period(CLK_HZ, 7))
  };

  state_t           r_state, w_state_nxt;
  logic             r_note_q;
  logic             w_beat;
  logic             w_load, w_finish;
  logic [IDX_W-1:0] w_load_idx;
  logic [3:0]       w_rom_arrows;
  logic [2:0]       w_rom_pitch;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_arrows;
  logic [2:0]       r_pitch;
  logic             r_valid, r_playing, r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_half_m1;
  logic             r_tone;

  assign w_beat = note_clk & ~r_note_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (start)                               w_state_nxt = S_PLAY;
        else if (pause)                          w_state_nxt = S_PAUSE;
        else if (w_beat && (r_idx == LAST_IDX))  w_state_nxt = S_DONE;
      end
      S_PAUSE: if (start || !pause) w_state_nxt = S_PLAY;
      S_DONE:  if (start) w_state_nxt = S_PLAY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // start reloads entry 0 from any state; beats only advance an unpaused PLAY.
  always_comb begin
    w_load     = 1'b0;
    w_finish   = 1'b0;
    w_load_idx = r_idx;
    if (start) begin
      w_load     = 1'b1;
      w_load_idx = '0;
    end else if ((r_state == S_PLAY) && !pause && w_beat) begin
      if (r_idx != LAST_IDX) begin
        w_load     = 1'b1;
        w_load_idx = r_idx + IDX_W'(1);
      end else begin
        w_finish = 1'b1;
      end
    end
  end

  song_rom #(
    .IDX_W (IDX_W)
  ) u_song_rom (
    .i_idx    (w_load_idx),
    .o_arrows (w_rom_arrows),
    .o_pitch  (w_rom_pitch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note_q  <= 1'b0;
      r_idx     <= '0;
      r_arrows  <= '0;
      r_pitch   <= P_REST;
      r_valid   <= 1'b0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_note_q  <= note_clk;
      r_valid   <= w_load;
      r_playing <= (w_state_nxt == S_PLAY);
      r_done    <= (w_state_nxt == S_DONE);
      if (w_load) begin
        r_idx    <= w_load_idx;
        r_arrows <= w_rom_arrows;
        r_pitch  <= w_rom_pitch;
      end else if (w_finish) begin
        r_arrows <= '0;
      end
    end
  end

  assign w_half_m1 = HP[r_pitch] - CNT_W'(1);

  // The counter keeps its phase across a pause; IDLE and DONE reset it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if ((r_state == S_PLAY) && (w_state_nxt == S_PLAY) && (r_pitch != P_REST)) begin
      if (r_cnt == w_half_m1) begin
        r_cnt  <= '0;
        r_tone <= ~r_tone;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if ((r_state == S_PAUSE) || (w_state_nxt == S_PAUSE)) begin
      r_tone <= 1'b0;
    end else begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end
  end

  assign arrows     = r_arrows;
  assign note_valid = r_valid;
  assign note_idx   = r_idx;
  assign tone       = r_tone;
  assign playing    = r_playing;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// tb_note_sequencer -- directed and random stimulus against a note-level reference model
module tb_note_sequencer;
  import note_pkg::*;

  localparam longint CLK_HZ_TB = 100000;
  localparam int     SONG_LEN  = 16;
  localparam int     IDX_W     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             note_clk = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [3:0]       arrows;
  logic             note_valid;
  logic [IDX_W-1:0] note_idx;
  logic             tone;
  logic             playing;
  logic             done;

  always #5 clk = ~clk;

  note_sequencer #(
    .CLK_HZ   (CLK_HZ_TB),
    .SONG_LEN (SONG_LEN),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .note_clk   (note_clk),
    .start      (start),
    .pause      (pause),
    .arrows     (arrows),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .tone       (tone),
    .playing    (playing),
    .done       (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: song position, mode, and cycles of tone since the note loaded.
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;
  int m_st, m_idx, m_el;
  bit m_known, m_valid, m_prev;
  bit pa_lvl = 1'b0;

  function automatic int song_pitch(input int i);
    int p [4] = '{6, 1, 0, 5};
    return p[i % 4];
  endfunction

  function automatic int song_arrows(input int i);
    return 1 << (i % 4);
  endfunction

  function automatic real freq_of(input int p);
    case (p)
      1: return 261.63;
      2: return 293.66;
      3: return 329.63;
      4: return 349.23;
      5: return 392.00;
      6: return 440.00;
      7: return 493.88;
      default: return 0.0;
    endcase
  endfunction

  function automatic int exp_half(input int p);
    return $rtoi(real'(CLK_HZ_TB) / (2.0 * freq_of(p)) + 0.5);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_idx = 0; m_el = 0;
    m_known = 1'b1; m_valid = 1'b0; m_prev = 1'b0;
  endtask

  task automatic model_step();
    bit beat;
    beat    = note_clk && !m_prev;
    m_prev  = note_clk;
    m_valid = 1'b0;
    if (start) begin
      m_st = M_PLAY; m_idx = 0; m_valid = 1'b1; m_el = 0; m_known = 1'b1;
    end else if (m_st == M_PLAY) begin
      if (pause) begin
        m_st = M_PAUSE; m_known = 1'b0;
      end else if (beat) begin
        if (m_idx < SONG_LEN - 1) begin
          m_idx++; m_valid = 1'b1; m_el = 0; m_known = 1'b1;
        end else begin
          m_st = M_DONE;
        end
      end else begin
        m_el++;
      end
    end else if (m_st == M_PAUSE) begin
      if (!pause) m_st = M_PLAY;
    end
  endtask

  task automatic compare_all();
    int exp_arrows, exp_tone, p;
    exp_arrows = (m_st == M_PLAY || m_st == M_PAUSE) ? song_arrows(m_idx) : 0;
    p = song_pitch(m_idx);
    exp_tone = (m_st == M_PLAY && p != 0) ? ((m_el / exp_half(p)) % 2) : 0;
    chk_eq("playing", playing, m_st == M_PLAY);
    chk_eq("done", done, m_st == M_DONE);
    chk_eq("note_idx", note_idx, m_idx);
    chk_eq("note_valid", note_valid, m_valid);
    chk_eq("arrows", arrows, exp_arrows);
    if (m_st != M_PLAY || m_known) chk_eq("tone", tone, exp_tone);
  endtask

  task automatic cyc(input logic st, input logic pa, input logic nc);
    @(negedge clk);
    start    = st;
    pause    = pa;
    note_clk = nc;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, pa_lvl, note_clk);
  endtask

  task automatic beat(input logic st, input logic pa);
    if (note_clk) cyc(1'b0, pa_lvl, 1'b0);
    cyc(st, pa, 1'b1);
  endtask

  int unsigned spec_hp [8] = '{0, 191110, 170265, 151685, 143172, 127551, 113636, 101239};
  int  hold;
  logic st_r, nc_r;

  initial begin
    for (int p = 1; p < 8; p++) chk_eq("hp_default", HALF_PERIOD[p], spec_hp[p]);

    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'(i % 2));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'(i % 2));

    cyc(1'b1, 1'b0, 1'b0);
    idle(300);
    beat(1'b0, 1'b0); idle(400);
    beat(1'b0, 1'b0); idle(100);
    beat(1'b0, 1'b0); idle(300);
    for (int i = 0; i < 13; i++) begin beat(1'b0, 1'b0); idle(30); end
    chk_eq("song_done", done, 1);
    beat(1'b0, 1'b0); idle(5);
    chk_eq("done_hold_idx", note_idx, SONG_LEN - 1);
    beat(1'b1, 1'b0); idle(20);

    beat(1'b0, 1'b0); idle(10);
    pa_lvl = 1'b1;
    beat(1'b0, 1'b1); idle(20);
    pa_lvl = 1'b0;
    idle(5);
    beat(1'b0, 1'b0); idle(10);
    chk_eq("pause_resume_idx", note_idx, 2);

    for (int i = 0; i < 3; i++) begin beat(1'b0, 1'b0); idle(10); end
    beat(1'b1, 1'b0);
    idle(150);
    chk_eq("tone_pre_rst", tone, 1);

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("rst_tone", tone, 0);
    chk_eq("rst_playing", playing, 0);
    chk_eq("rst_arrows", arrows, 0);
    chk_eq("rst_idx", note_idx, 0);
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    cyc(1'b1, 1'b0, 1'b0);
    hold = 0;
    nc_r = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      st_r = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 199) == 0) pa_lvl = ~pa_lvl;
      if (hold == 0) begin
        nc_r = ~nc_r;
        hold = int'($urandom_range(20, 200));
      end else begin
        hold--;
      end
      cyc(st_r, pa_lvl, nc_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
